// File: rtl/lcd_rx.sv
// HD44780-style 4-bit receiver: nibble assembly, command decode and a small DDRAM.
// Define LCD_RX_CLEAR_SWEEP_EN to make clear sweep the DDRAM one entry per cycle with busy/overrun.
module lcd_rx #(
  parameter int unsigned ADDR_W = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic              rs,
  input  logic [3:0]        data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [7:0]        rd_data,
  output logic [ADDR_W-1:0] cursor,
  output logic              display_on,
  output logic              mode_4bit,
  output logic              busy,
  output logic              overrun,
  output logic              byte_valid,
  output logic [7:0]        byte_out
);

  localparam int unsigned        DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0]  ONE   = ADDR_W'(1);

  typedef enum logic [1:0] {BOOT8, HI, LO} state_e;

  state_e              state_q, state_d;
  logic                en_prev_q, en_prev_d;
  logic [3:0]          lat_data_q, lat_data_d;
  logic                lat_rs_q, lat_rs_d;
  logic [3:0]          hi_q, hi_d;
  logic                hi_rs_q, hi_rs_d;
  logic [ADDR_W-1:0]   cursor_q, cursor_d;
  logic                inc_q, inc_d;
  logic                display_on_q, display_on_d;
  logic                mode_4bit_q, mode_4bit_d;
  logic                byte_valid_q, byte_valid_d;
  logic [7:0]          byte_out_q, byte_out_d;
  logic [7:0]          mem_q [DEPTH];

  logic                wr_en;
  logic [ADDR_W-1:0]   wr_addr;
  logic [7:0]          wr_data;
  logic                commit, accept, busy_w;
  logic [7:0]          full_byte;
  logic                fset_dl;

`ifdef LCD_RX_CLEAR_SWEEP_EN
  logic                busy_q, busy_d;
  logic                overrun_q, overrun_d;
  logic [ADDR_W-1:0]   sweep_q, sweep_d;
  assign busy_w = busy_q;
`else
  assign busy_w = 1'b0;
`endif

  // A transfer commits on the first idle cycle after the strobe, using the latched bus.
  assign commit    = en_prev_q & ~en;
  assign accept    = commit & ~busy_w;
  assign full_byte = {hi_q, lat_data_q};
  assign fset_dl   = ~hi_rs_q & (full_byte[7:4] == 4'b0011);

  always_ff @(posedge clk) begin
    if (reset) state_q <= BOOT8;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (accept) begin
      unique case (state_q)
        BOOT8:   if (lat_data_q == 4'h2) state_d = HI;
        HI:      state_d = LO;
        LO:      state_d = fset_dl ? BOOT8 : HI;
        default: state_d = BOOT8;
      endcase
    end
  end

  always_comb begin
    en_prev_d    = en;
    lat_data_d   = en ? data : lat_data_q;
    lat_rs_d     = en ? rs : lat_rs_q;
    hi_d         = hi_q;
    hi_rs_d      = hi_rs_q;
    cursor_d     = cursor_q;
    inc_d        = inc_q;
    display_on_d = display_on_q;
    mode_4bit_d  = mode_4bit_q;
    byte_valid_d = 1'b0;
    byte_out_d   = byte_out_q;
    wr_en        = 1'b0;
    wr_addr      = cursor_q;
    wr_data      = full_byte;
`ifdef LCD_RX_CLEAR_SWEEP_EN
    busy_d       = busy_q;
    overrun_d    = overrun_q;
    sweep_d      = sweep_q;
`endif
    if (accept) begin
      unique case (state_q)
        BOOT8: if (lat_data_q == 4'h2) mode_4bit_d = 1'b1;
        HI: begin
          hi_d    = lat_data_q;
          hi_rs_d = lat_rs_q;
        end
        LO: begin
          byte_valid_d = 1'b1;
          byte_out_d   = full_byte;
          if (hi_rs_q) begin
            wr_en    = 1'b1;
            cursor_d = inc_q ? cursor_q + ONE : cursor_q - ONE;
          end else if (full_byte[7]) begin
            cursor_d = full_byte[ADDR_W-1:0];
          end else if (full_byte[6]) begin
            cursor_d = cursor_q;
          end else if (full_byte[5]) begin
            if (full_byte[4]) mode_4bit_d = 1'b0;
          end else if (full_byte[4]) begin
            cursor_d = cursor_q;
          end else if (full_byte[3]) begin
            display_on_d = full_byte[2];
          end else if (full_byte[2]) begin
            inc_d = full_byte[1];
          end else if (full_byte[1]) begin
            cursor_d = '0;
          end else if (full_byte[0]) begin
`ifdef LCD_RX_CLEAR_SWEEP_EN
            busy_d  = 1'b1;
            sweep_d = '0;
`else
            cursor_d = '0;
            inc_d    = 1'b1;
`endif
          end
        end
        default: ;
      endcase
    end
`ifdef LCD_RX_CLEAR_SWEEP_EN
    if (busy_q) begin
      wr_en   = 1'b1;
      wr_addr = sweep_q;
      wr_data = 8'h20;
      sweep_d = sweep_q + ONE;
      if (sweep_q == '1) begin
        busy_d   = 1'b0;
        cursor_d = '0;
        inc_d    = 1'b1;
      end
    end
    if (commit && busy_q) overrun_d = 1'b1;
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      en_prev_q    <= 1'b0;
      lat_data_q   <= '0;
      lat_rs_q     <= 1'b0;
      hi_q         <= '0;
      hi_rs_q      <= 1'b0;
      cursor_q     <= '0;
      inc_q        <= 1'b1;
      display_on_q <= 1'b0;
      mode_4bit_q  <= 1'b0;
      byte_valid_q <= 1'b0;
      byte_out_q   <= '0;
`ifdef LCD_RX_CLEAR_SWEEP_EN
      busy_q       <= 1'b0;
      overrun_q    <= 1'b0;
      sweep_q      <= '0;
`endif
    end else begin
      en_prev_q    <= en_prev_d;
      lat_data_q   <= lat_data_d;
      lat_rs_q     <= lat_rs_d;
      hi_q         <= hi_d;
      hi_rs_q      <= hi_rs_d;
      cursor_q     <= cursor_d;
      inc_q        <= inc_d;
      display_on_q <= display_on_d;
      mode_4bit_q  <= mode_4bit_d;
      byte_valid_q <= byte_valid_d;
      byte_out_q   <= byte_out_d;
`ifdef LCD_RX_CLEAR_SWEEP_EN
      busy_q       <= busy_d;
      overrun_q    <= overrun_d;
      sweep_q      <= sweep_d;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (reset)      mem_q <= '{default: 8'h20};
    else if (wr_en) mem_q[wr_addr] <= wr_data;
  end

  always_comb begin
    rd_data    = mem_q[rd_addr];
    cursor     = cursor_q;
    display_on = display_on_q;
    mode_4bit  = mode_4bit_q;
    byte_valid = byte_valid_q;
    byte_out   = byte_out_q;
`ifdef LCD_RX_CLEAR_SWEEP_EN
    busy       = busy_q;
    overrun    = overrun_q;
`else
    busy       = 1'b0;
    overrun    = 1'b0;
`endif
  end

endmodule

// File: tb/tb_lcd_rx.sv
// Directed bench for lcd_rx: boot, command/data table, wrap, clear, overrun and reset cases.
module tb_lcd_rx;

  logic       clk = 1'b0;
  logic       reset, en, rs;
  logic [3:0] data;
  logic [4:0] rd_addr;
  logic [7:0] rd_data;
  logic [4:0] cursor;
  logic       display_on, mode_4bit, busy, overrun, byte_valid;
  logic [7:0] byte_out;

  int total = 0;
  int bad   = 0;
  int bv_cnt = 0;

`ifdef LCD_RX_CLEAR_SWEEP_EN
  localparam int SWEEP_N = 32;
`else
  localparam int SWEEP_N = 0;
`endif

  lcd_rx #(.ADDR_W(5)) dut (
    .clk(clk), .reset(reset), .en(en), .rs(rs), .data(data),
    .rd_addr(rd_addr), .rd_data(rd_data), .cursor(cursor),
    .display_on(display_on), .mode_4bit(mode_4bit), .busy(busy),
    .overrun(overrun), .byte_valid(byte_valid), .byte_out(byte_out)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (byte_valid === 1'b1) bv_cnt++;

  typedef struct {
    logic       rs;
    logic [7:0] b;
    logic [4:0] cur;
    logic       disp;
    logic       mode;
    int         busy_n;
  } vec_t;

  vec_t tbl [22];
  logic [7:0] exp_mem [32];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic rd_chk(input int a, input logic [7:0] exp);
    rd_addr = 5'(a);
    #1;
    chk($sformatf("ddram[%0d]", a), {24'h0, rd_data}, {24'h0, exp});
  endtask

  task automatic nib(input logic r, input logic [3:0] d);
    @(negedge clk); en = 1'b1; rs = r; data = d;
    @(negedge clk); en = 1'b0;
  endtask

  task automatic send_byte(input logic r, input logic [7:0] b);
    nib(r, b[7:4]);
    nib(r, b[3:0]);
    @(negedge clk);
  endtask

  task automatic wait_busy(output int n);
    n = 0;
    while (busy === 1'b1 && n < 200) begin
      n++;
      @(negedge clk);
    end
  endtask

  initial begin
    int n, bv0;
    tbl[0]  = '{1'b0, 8'h28, 5'd0,  1'b0, 1'b1, 0};
    tbl[1]  = '{1'b0, 8'h0C, 5'd0,  1'b1, 1'b1, 0};
    tbl[2]  = '{1'b0, 8'h06, 5'd0,  1'b1, 1'b1, 0};
    tbl[3]  = '{1'b0, 8'h01, 5'd0,  1'b1, 1'b1, SWEEP_N};
    tbl[4]  = '{1'b0, 8'h80, 5'd0,  1'b1, 1'b1, 0};
    tbl[5]  = '{1'b1, 8'h31, 5'd1,  1'b1, 1'b1, 0};
    tbl[6]  = '{1'b1, 8'h32, 5'd2,  1'b1, 1'b1, 0};
    tbl[7]  = '{1'b1, 8'h3A, 5'd3,  1'b1, 1'b1, 0};
    tbl[8]  = '{1'b1, 8'h33, 5'd4,  1'b1, 1'b1, 0};
    tbl[9]  = '{1'b1, 8'h34, 5'd5,  1'b1, 1'b1, 0};
    tbl[10] = '{1'b0, 8'h85, 5'd5,  1'b1, 1'b1, 0};
    tbl[11] = '{1'b0, 8'h02, 5'd0,  1'b1, 1'b1, 0};
    tbl[12] = '{1'b0, 8'h08, 5'd0,  1'b0, 1'b1, 0};
    tbl[13] = '{1'b0, 8'h0C, 5'd0,  1'b1, 1'b1, 0};
    tbl[14] = '{1'b0, 8'h10, 5'd0,  1'b1, 1'b1, 0};
    tbl[15] = '{1'b0, 8'h47, 5'd0,  1'b1, 1'b1, 0};
    tbl[16] = '{1'b0, 8'h9F, 5'd31, 1'b1, 1'b1, 0};
    tbl[17] = '{1'b0, 8'h06, 5'd31, 1'b1, 1'b1, 0};
    tbl[18] = '{1'b1, 8'h41, 5'd0,  1'b1, 1'b1, 0};
    tbl[19] = '{1'b0, 8'h04, 5'd0,  1'b1, 1'b1, 0};
    tbl[20] = '{1'b1, 8'h42, 5'd31, 1'b1, 1'b1, 0};
    tbl[21] = '{1'b0, 8'h00, 5'd31, 1'b1, 1'b1, 0};
    for (int i = 0; i < 32; i++) exp_mem[i] = 8'h20;
    exp_mem[0] = 8'h42; exp_mem[1] = 8'h32; exp_mem[2] = 8'h3A;
    exp_mem[3] = 8'h33; exp_mem[4] = 8'h34; exp_mem[31] = 8'h41;

    reset = 1'b1; en = 1'b0; rs = 1'b0; data = 4'h0; rd_addr = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    chk("rst_cursor", 32'(cursor), 0);
    chk("rst_display", 32'(display_on), 0);
    chk("rst_mode", 32'(mode_4bit), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_overrun", 32'(overrun), 0);
    chk("rst_bvalid", 32'(byte_valid), 0);
    chk("rst_byte_out", 32'(byte_out), 0);
    rd_chk(7, 8'h20);

    // 8-bit boot handshake; stray nibble 5 ignored
    nib(1'b0, 4'h5); @(negedge clk);
    chk("boot_n5_mode", 32'(mode_4bit), 0);
    for (int i = 0; i < 3; i++) begin
      nib(1'b0, 4'h3); @(negedge clk);
      chk($sformatf("boot_3_%0d_mode", i), 32'(mode_4bit), 0);
    end
    nib(1'b0, 4'h2); @(negedge clk);
    chk("boot_2_mode", 32'(mode_4bit), 1);
    @(negedge clk);
    chk("boot_no_bytes", 32'(bv_cnt), 0);

    for (int i = 0; i < 22; i++) begin
      bv0 = bv_cnt;
      send_byte(tbl[i].rs, tbl[i].b);
      chk($sformatf("v%0d_bvalid", i), 32'(byte_valid), 1);
      chk($sformatf("v%0d_byte_out", i), 32'(byte_out), 32'(tbl[i].b));
      wait_busy(n);
      chk($sformatf("v%0d_busy_cycles", i), 32'(n), 32'(tbl[i].busy_n));
      chk($sformatf("v%0d_cursor", i), 32'(cursor), 32'(tbl[i].cur));
      chk($sformatf("v%0d_display", i), 32'(display_on), 32'(tbl[i].disp));
      chk($sformatf("v%0d_mode", i), 32'(mode_4bit), 32'(tbl[i].mode));
      @(negedge clk);
      chk($sformatf("v%0d_pulses", i), 32'(bv_cnt), 32'(bv0 + 1));
    end
    for (int i = 0; i < 32; i++) rd_chk(i, exp_mem[i]);

    // rs of the high nibble decides: 0x41 is written as data (inc=0 now)
    send_byte(1'b0, 8'h8A);
    nib(1'b1, 4'h4); nib(1'b0, 4'h1); @(negedge clk);
    rd_chk(10, 8'h41);
    chk("rs_mix_cursor", 32'(cursor), 9);

    // function set with DL=1 drops back to 8-bit boot
    send_byte(1'b0, 8'h30);
    chk("dl8_mode", 32'(mode_4bit), 0);
    nib(1'b0, 4'h2); @(negedge clk);
    chk("dl8_reenter_mode", 32'(mode_4bit), 1);
    send_byte(1'b1, 8'h55);
    rd_chk(9, 8'h55);
    chk("dl8_cursor", 32'(cursor), 8);

    send_byte(1'b0, 8'h01);
`ifdef LCD_RX_CLEAR_SWEEP_EN
    chk("clr_busy", 32'(busy), 1);
    nib(1'b1, 4'h7);
    wait_busy(n);
    chk("clr_busy_rest", 32'(n), 30);
    chk("clr_overrun", 32'(overrun), 1);
    chk("clr_cursor", 32'(cursor), 0);
    for (int i = 0; i < 32; i++) rd_chk(i, 8'h20);
    send_byte(1'b1, 8'h35);
    rd_chk(0, 8'h35);
    chk("post_clr_cursor", 32'(cursor), 1);
    chk("overrun_sticky", 32'(overrun), 1);
`else
    chk("clr_busy", 32'(busy), 0);
    chk("clr_cursor", 32'(cursor), 0);
    rd_chk(10, 8'h41);
    send_byte(1'b1, 8'h35);
    rd_chk(0, 8'h35);
    chk("post_clr_cursor", 32'(cursor), 1);
    chk("no_overrun", 32'(overrun), 0);
`endif

    // reset after a lone high nibble, colliding with the next falling edge
    nib(1'b1, 4'h4);
    @(negedge clk); en = 1'b1; rs = 1'b1; data = 4'h1;
    @(negedge clk); en = 1'b0; reset = 1'b1;
    bv0 = bv_cnt;
    @(negedge clk); reset = 1'b0;
    chk("mid_rst_mode", 32'(mode_4bit), 0);
    chk("mid_rst_cursor", 32'(cursor), 0);
    chk("mid_rst_overrun", 32'(overrun), 0);
    chk("mid_rst_display", 32'(display_on), 0);
    rd_chk(0, 8'h20);
    nib(1'b0, 4'h3); @(negedge clk); @(negedge clk);
    chk("mid_rst_no_byte", 32'(bv_cnt), 32'(bv0));
    chk("mid_rst_mode_after3", 32'(mode_4bit), 0);
    nib(1'b0, 4'h2); @(negedge clk);
    chk("mid_rst_mode_after2", 32'(mode_4bit), 1);
    send_byte(1'b1, 8'h4B);
    rd_chk(0, 8'h4B);
    chk("mid_rst_cursor_after", 32'(cursor), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running want finished");
    $fatal(1, "timeout");
  end

endmodule
